// File: rtl/alu_muldiv_seq_pkg.sv
// Shared op encodings and FSM state type for the RV32 execute unit.
// in_op[4] selects the M extension; base ops use the low nibble as ALU select.
package alu_muldiv_seq_pkg;

  localparam int OP_W        = 5;
  localparam int OP_MODE_BIT = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [OP_W-1:0] m_op(input logic [2:0] funct3);
    return {1'b1, 1'b0, funct3};
  endfunction

  function automatic logic [OP_W-1:0] base_op(input alu_op_e sel);
    return {1'b0, sel};
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_muldiv_iter.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign fix-up applied to the final step.
module muldiv_iter
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  hi_reg, lo_reg, opnd_reg;
  logic [XLEN-1:0]  hi_next, lo_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg, is_div_reg, sel_reg, a_neg_reg, b_neg_reg, b_zero_reg;

  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_div   = funct3[2];
  assign a_signed = (funct3 == M_MULH) || (funct3 == M_MULHSU) ||
                    (funct3 == M_DIV)  || (funct3 == M_REM);
  assign b_signed = (funct3 == M_MULH) || (funct3 == M_DIV) || (funct3 == M_REM);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign mag_a    = a_neg ? -a : a;
  assign mag_b    = b_neg ? -b : b;

  // Multiply: hi:lo is the product with the multiplier shifting out of lo.
  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  logic [XLEN:0] mul_sum, div_shift, div_diff;
  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign div_shift = {hi_reg, lo_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};

  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (is_div_reg) begin
      if (!div_diff[XLEN]) begin
        hi_next = div_diff[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        hi_next = div_shift[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      sel_reg    <= 1'b0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= is_div ? mag_a : mag_b;
      opnd_reg   <= is_div ? mag_b : mag_a;
      is_div_reg <= is_div;
      sel_reg    <= is_div ? funct3[1] : (funct3[1:0] != 2'b00);
      a_neg_reg  <= a_neg;
      b_neg_reg  <= b_neg;
      b_zero_reg <= (b == '0);
    end else if (busy_reg) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
      if (cnt_reg == CNT_W'(XLEN - 1)) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Result is taken from the post-step values so it is ready on the last iteration.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  assign prod     = {hi_next, lo_next};
  assign prod_fix = (a_neg_reg ^ b_neg_reg) ? -prod : prod;
  assign quo_fix  = b_zero_reg ? '1 : ((a_neg_reg ^ b_neg_reg) ? -lo_next : lo_next);
  assign rem_fix  = a_neg_reg ? -hi_next : hi_next;

  assign done   = busy_reg && (cnt_reg == CNT_W'(XLEN - 1));
  assign result = is_div_reg ? (sel_reg ? rem_fix : quo_fix)
                             : (sel_reg ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);

endmodule

// File: rtl/alu_muldiv_seq.sv
// RV32 execute unit: single-cycle base ALU plus iterative RV32M, with valid/ready
// handshakes on both sides and one operation in flight.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int SHAMT_W = $clog2(XLEN);

  state_e          state_reg;
  logic            accept, is_m, m_legal, base_legal, op_legal, m_start, mdu_done;
  logic [XLEN-1:0] base_result, mdu_result;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_m     = in_op[OP_MODE_BIT];
  assign m_legal  = ENABLE_M && is_m && !in_op[3];
  assign op_legal = is_m ? m_legal : base_legal;
  assign m_start  = accept && m_legal;
  assign shamt    = in_b[SHAMT_W-1:0];

  always_comb begin
    base_result = '0;
    base_legal  = 1'b1;
    case (alu_op_e'(in_op[3:0]))
      ALU_ADD:  base_result = in_a + in_b;
      ALU_SUB:  base_result = in_a - in_b;
      ALU_SLL:  base_result = in_a << shamt;
      ALU_SLT:  base_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU: base_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      ALU_XOR:  base_result = in_a ^ in_b;
      ALU_SRL:  base_result = in_a >> shamt;
      ALU_SRA:  base_result = $signed(in_a) >>> shamt;
      ALU_OR:   base_result = in_a | in_b;
      ALU_AND:  base_result = in_a & in_b;
      default:  base_legal  = 1'b0;
    endcase
  end

  generate
    if (ENABLE_M) begin : g_muldiv
      muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (m_start),
        .funct3 (in_op[2:0]),
        .a      (in_a),
        .b      (in_b),
        .done   (mdu_done),
        .result (mdu_result)
      );
    end else begin : g_no_muldiv
      assign mdu_done   = 1'b0;
      assign mdu_result = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state_reg)
        ST_BUSY: begin
          if (mdu_done) begin
            state_reg   <= ST_DONE;
            out_valid   <= 1'b1;
            out_result  <= mdu_result;
            out_illegal <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE share the accept path so a taken result can be replaced in one cycle.
          if (accept) begin
            if (m_start) begin
              state_reg <= ST_BUSY;
              out_valid <= 1'b0;
            end else begin
              state_reg   <= ST_DONE;
              out_valid   <= 1'b1;
              out_result  <= op_legal ? base_result : '0;
              out_illegal <= !op_legal;
            end
          end else if ((state_reg == ST_DONE) && out_ready) begin
            state_reg <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: base ops, RV32M ops, division corners,
// reset mid-operation, backpressure and illegal codes (with and without M).
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [4:0]  in_op;
  logic [31:0] in_a, in_b, out_result;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_out_illegal;
  logic [4:0]  n_in_op;
  logic [31:0] n_in_a, n_in_b, n_out_result;

  int checks   = 0;
  int failures = 0;

  alu_muldiv_seq #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_illegal(out_illegal)
  );

  alu_muldiv_seq #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op), .in_a(n_in_a), .in_b(n_in_b),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_result(n_out_result), .out_illegal(n_out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; leaves the result valid with out_ready=1.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic exp_ill,
                       input int exp_lat);
    int lat;
    out_ready = 1'b1;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 32'hDEAD_BEEF;
    in_b = 32'hDEAD_BEEF;
    lat = 1;
    if (exp_lat > 1) check({tag, " busy in_ready"}, in_ready, 0);
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, out_result, exp);
    check({tag, " illegal"}, out_illegal, exp_ill);
    $display("op %-12s a=%08h b=%08h -> %08h ill=%0d lat=%0d", tag, a, b, out_result, out_illegal, lat);
  endtask

  logic seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_op = '0; n_in_a = '0; n_in_b = '0; n_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset out_valid", out_valid, 0);
    check("reset out_result", out_result, 0);
    check("reset out_illegal", out_illegal, 0);
    check("reset in_ready", in_ready, 1);

    // Reset in the middle of a divide: the result must never appear.
    in_op = m_op(M_DIV); in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst no stale result", seen, 0);

    // Base ops back to back.
    do_op("ADD wrap", base_op(ALU_ADD), 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    do_op("SRA", base_op(ALU_SRA), 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
    do_op("SLTU", base_op(ALU_SLTU), 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1);
    do_op("SLT", base_op(ALU_SLT), 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    do_op("SUB wrap", base_op(ALU_SUB), 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1);
    do_op("SLL", base_op(ALU_SLL), 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, 1);
    do_op("SRL", base_op(ALU_SRL), 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1);
    do_op("XOR", base_op(ALU_XOR), 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1);

    // Multiplies.
    do_op("MULH", m_op(M_MULH), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
    do_op("MULHSU", m_op(M_MULHSU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("MUL", m_op(M_MUL), 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    do_op("MULHU", m_op(M_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);

    // Division corners.
    do_op("DIV -7/2", m_op(M_DIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    do_op("REM -7/2", m_op(M_REM), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("DIVU 5/0", m_op(M_DIVU), 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("REMU 5/0", m_op(M_REMU), 32'd5, 32'd0, 32'd5, 1'b0, 33);
    do_op("DIV -5/0", m_op(M_DIV), 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("REM -5/0", m_op(M_REM), 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b0, 33);
    do_op("DIV ovf", m_op(M_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33);
    do_op("REM ovf", m_op(M_REM), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
    do_op("DIVU 100/7", m_op(M_DIVU), 32'd100, 32'd7, 32'd14, 1'b0, 33);
    do_op("REMU 100/7", m_op(M_REMU), 32'd100, 32'd7, 32'd2, 1'b0, 33);

    // Backpressure: hold the result, then accept a new op on the out_ready pulse.
    in_op = base_op(ALU_ADD); in_a = 32'd3; in_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp held result", out_result, 32'd7);
      check("bp in_ready", in_ready, 0);
      check("bp out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_op = base_op(ALU_SUB); in_a = 32'd10; in_b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("bp pulse in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp next out_valid", out_valid, 1);
    check("bp next result", out_result, 32'd7);
    @(posedge clk); #1;
    check("bp next held", out_valid, 1);
    $display("op %-12s a=%08h b=%08h -> %08h ill=%0d", "SUB bp", 32'd10, 32'd3, out_result, out_illegal);

    // Illegal codes.
    do_op("ILLEGAL 0F", 5'b0_1111, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 1);
    do_op("ADD after ill", base_op(ALU_ADD), 32'd2, 32'd2, 32'd4, 1'b0, 1);

    // M op on an instance built without the M extension.
    n_in_op = m_op(M_MUL); n_in_a = 32'd7; n_in_b = 32'd3; n_in_valid = 1'b1;
    @(negedge clk);
    check("noM in_ready", n_in_ready, 1);
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    check("noM MUL out_valid", n_out_valid, 1);
    check("noM MUL illegal", n_out_illegal, 1);
    check("noM MUL result", n_out_result, 32'h0);
    $display("op %-12s a=%08h b=%08h -> %08h ill=%0d", "noM MUL", 32'd7, 32'd3, n_out_result, n_out_illegal);
    n_in_op = base_op(ALU_OR); n_in_a = 32'h00F0; n_in_b = 32'h0F00; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    check("noM OR result", n_out_result, 32'h0FF0);
    check("noM OR illegal", n_out_illegal, 0);
    $display("op %-12s a=%08h b=%08h -> %08h ill=%0d", "noM OR", 32'h00F0, 32'h0F00, n_out_result, n_out_illegal);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
